// File: rtl/rd_capture_lgc_pkg.sv
// Shared types and elaboration helpers for the DDR5 read-burst capture block.
package rd_capture_lgc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

    // Position of each beat inside a clk-cycle beat pair.
    localparam int RISE_OFS = 0;
    localparam int FALL_OFS = 1;

    function automatic bit bl_legal(input int bl);
        return (bl >= 2) && ((bl % 2) == 0);
    endfunction

    // Beat-pair counter must hold BL/2 without wrapping.
    function automatic int bcnt_w(input int bl);
        return $clog2(bl / 2) + 1;
    endfunction

endpackage

// File: rtl/rd_capture_lgc_if.sv
// Read-capture bus: command side, deserializer beats and read-return outputs.
// The DBI flag signals exist only when RD_DBI_EN is defined.
interface rd_capture_lgc_if #(
    parameter int BL   = 2,
    parameter int DQ_W = 8,
    parameter int CLW  = 6
);
    logic                 rd_cmd;
    logic [CLW-1:0]       cl;
    logic                 rd_rdy;
    logic [DQ_W-1:0]      dq_rise;
    logic [DQ_W-1:0]      dq_fall;
`ifdef RD_DBI_EN
    logic                 dbi_n_rise;
    logic                 dbi_n_fall;
`endif
    logic [BL*DQ_W-1:0]   rd_data;
    logic                 rd_valid;
    logic                 rd_ovf;

`ifdef RD_DBI_EN
    modport master (output rd_cmd, cl, dq_rise, dq_fall, dbi_n_rise, dbi_n_fall,
                    input  rd_rdy, rd_data, rd_valid, rd_ovf);
    modport slave  (input  rd_cmd, cl, dq_rise, dq_fall, dbi_n_rise, dbi_n_fall,
                    output rd_rdy, rd_data, rd_valid, rd_ovf);
`else
    modport master (output rd_cmd, cl, dq_rise, dq_fall,
                    input  rd_rdy, rd_data, rd_valid, rd_ovf);
    modport slave  (input  rd_cmd, cl, dq_rise, dq_fall,
                    output rd_rdy, rd_data, rd_valid, rd_ovf);
`endif
endinterface

// File: rtl/rd_capture_lgc_lat_cntr.sv
// Loadable down-counter that saturates at zero; used for CAS wait and beat-pair count.
module rd_capture_lgc_lat_cntr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/rd_capture_lgc.sv
// Captures one DDR5 read burst after a programmable CAS latency and pulses rd_valid.
// Define RD_DBI_EN to add read-DBI inversion of beats flagged with dbi_n=0.
//
//   state   | meaning
//   IDLE    | ready for rd_cmd; rd_rdy=1
//   WAIT    | counting down the latched CAS latency
//   CAPT    | sampling one rise/fall beat pair per clk
module rd_capture_lgc
    import rd_capture_lgc_pkg::*;
#(
    parameter int BL   = 2,
    parameter int DQ_W = 8,
    parameter int CLW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    rd_capture_lgc_if.slave    bus
);
    localparam int NPAIR = BL / 2;
    localparam int BW    = bcnt_w(BL);

    generate
        if (!bl_legal(BL)) begin : g_bl_chk
            $error("rd_capture_lgc: BL must be even and >= 2");
        end
    endgenerate

    state_e               state_q;
    logic                 rd_valid_q;
    logic                 rd_ovf_q;
    logic [BL*DQ_W-1:0]   rd_data_q;

    logic [CLW-1:0]       wcnt;
    logic                 wzero;
    logic [BW-1:0]        bcnt;
    logic                 bzero;
    logic                 rdy;
    logic                 accept;
    logic                 wait_done;
    logic                 capt_last;
    logic                 capt_entry;
    logic [BW-1:0]        beat_idx;
    logic [NPAIR-1:0]     pair_we;
    logic [DQ_W-1:0]      rise_beat;
    logic [DQ_W-1:0]      fall_beat;

    assign rdy        = (state_q == ST_IDLE);
    assign accept     = bus.rd_cmd && rdy;
    // Zero checks are a safe exit should a counter ever be empty in that state.
    assign wait_done  = (state_q == ST_WAIT) && ((wcnt == CLW'(1)) || wzero);
    assign capt_last  = (state_q == ST_CAPT) && ((bcnt == BW'(1)) || bzero);
    assign capt_entry = (accept && (bus.cl == '0)) || wait_done;
    assign beat_idx   = BW'(NPAIR) - bcnt;

`ifdef RD_DBI_EN
    assign rise_beat = bus.dbi_n_rise ? bus.dq_rise : ~bus.dq_rise;
    assign fall_beat = bus.dbi_n_fall ? bus.dq_fall : ~bus.dq_fall;
`else
    assign rise_beat = bus.dq_rise;
    assign fall_beat = bus.dq_fall;
`endif

    always_comb begin
        pair_we = '0;
        for (int k = 0; k < NPAIR; k++) begin
            pair_we[k] = (state_q == ST_CAPT) && (beat_idx == BW'(k));
        end
    end

    rd_capture_lgc_lat_cntr #(.W(CLW)) u_wait_cntr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.cl),
        .en       (state_q == ST_WAIT),
        .cnt      (wcnt),
        .zero     (wzero)
    );

    rd_capture_lgc_lat_cntr #(.W(BW)) u_beat_cntr (
        .clk      (clk),
        .rst      (rst),
        .load     (capt_entry),
        .load_val (BW'(NPAIR)),
        .en       (state_q == ST_CAPT),
        .cnt      (bcnt),
        .zero     (bzero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            rd_ovf_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= capt_last;
            rd_ovf_q   <= bus.rd_cmd && !rdy;
            case (state_q)
                ST_IDLE: if (accept) state_q <= (bus.cl == '0) ? ST_CAPT : ST_WAIT;
                ST_WAIT: if (wait_done) state_q <= ST_CAPT;
                ST_CAPT: if (capt_last) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
            for (int k = 0; k < NPAIR; k++) begin
                if (pair_we[k]) begin
                    rd_data_q[(2*k+RISE_OFS)*DQ_W +: DQ_W] <= rise_beat;
                    rd_data_q[(2*k+FALL_OFS)*DQ_W +: DQ_W] <= fall_beat;
                end
            end
        end
    end

    assign bus.rd_rdy   = rdy;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_ovf   = rd_ovf_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_rd_capture_lgc.sv
// Drives BL=2 and BL=8 instances with shared stimulus and compares against a cycle-count model.
module tb_rd_capture_lgc;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_cmd = 1'b0;
    logic [5:0] cl = '0;
    logic [7:0] dq_rise = '0;
    logic [7:0] dq_fall = '0;
    logic       dbi_n_rise = 1'b1;
    logic       dbi_n_fall = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [7:0] stored_beat(input logic [7:0] d, input logic dbn);
        return dbn ? d : ~d;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int BLG = (g == 0) ? 2 : 8;
        localparam int NP  = BLG / 2;

        rd_capture_lgc_if #(.BL(BLG), .DQ_W(8), .CLW(6)) u_if ();

        assign u_if.rd_cmd  = rd_cmd;
        assign u_if.cl      = cl;
        assign u_if.dq_rise = dq_rise;
        assign u_if.dq_fall = dq_fall;
`ifdef RD_DBI_EN
        assign u_if.dbi_n_rise = dbi_n_rise;
        assign u_if.dbi_n_fall = dbi_n_fall;
`endif

        rd_capture_lgc #(.BL(BLG), .DQ_W(8), .CLW(6)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );

        // Reference: a burst accepted in cycle T captures in T+cl+1 .. T+cl+NP,
        // and the block is idle again (with rd_valid) at T+cl+NP+1.
        int          cyc = 0;
        int          busy_until = 0;
        int          start = -1000;
        int          valid_at = -1;
        int          c;
        int          i;
        bit          idle;
        bit          live = 0;
        logic        ovf_e = 1'b0;
        logic        valid_e = 1'b0;
        logic [63:0] data_e = '0;

        always @(posedge clk) begin
            c = cyc;
            if (!rst) begin
                busy_until = c + 1;
                start      = -1000;
                valid_at   = -1;
                data_e     = '0;
                ovf_e      = 1'b0;
                valid_e    = 1'b0;
                live       = 1;
            end else begin
                idle  = (c >= busy_until);
                ovf_e = rd_cmd && !idle;
                if (rd_cmd && idle) begin
                    start      = c + int'(cl) + 1;
                    busy_until = start + NP;
                    valid_at   = busy_until;
                end
                if (c >= start && c < start + NP) begin
                    i = c - start;
                    data_e[(2*i)*8 +: 8]   = stored_beat(dq_rise, dbi_n_rise);
                    data_e[(2*i+1)*8 +: 8] = stored_beat(dq_fall, dbi_n_fall);
                end
                valid_e = (c + 1 == valid_at);
            end
            cyc++;
        end

        always @(negedge clk) begin
            if (live) begin
                chk($sformatf("bl%0d_rdy", BLG),   64'(u_if.rd_rdy),   64'(cyc >= busy_until));
                chk($sformatf("bl%0d_valid", BLG), 64'(u_if.rd_valid), 64'(valid_e));
                chk($sformatf("bl%0d_ovf", BLG),   64'(u_if.rd_ovf),   64'(ovf_e));
                chk($sformatf("bl%0d_data", BLG),  64'(u_if.rd_data),  data_e);
            end
        end
    end

    task automatic drive(input logic cmd, input logic [5:0] cl_v,
                         input logic [7:0] r, input logic [7:0] f);
        @(negedge clk);
        rd_cmd     = cmd;
        cl         = cl_v;
        dq_rise    = r;
        dq_fall    = f;
        dbi_n_rise = 1'b1;
        dbi_n_fall = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 6'd0, 8'h00, 8'h00);
    endtask

    initial begin
        rst = 1'b0;
        idle_cycles(3);
        chk("rst_rdy",  64'(g_dut[0].u_if.rd_rdy), 64'd1);
        chk("rst_data", 64'(g_dut[1].u_if.rd_data), 64'd0);
        @(negedge clk) rst = 1'b1;
        idle_cycles(2);

        // BL=2, cl=3: beats presented at T+4, valid at T+5
        drive(1'b1, 6'd3, 8'h00, 8'h00);
        idle_cycles(3);
        drive(1'b0, 6'd0, 8'hA5, 8'h3C);
        chk("t1_early", 64'(g_dut[0].u_if.rd_valid), 64'd0);
        drive(1'b0, 6'd0, 8'h00, 8'h00);
        chk("t1_valid", 64'(g_dut[0].u_if.rd_valid), 64'd1);
        chk("t1_data",  64'(g_dut[0].u_if.rd_data),  64'h3CA5);
        idle_cycles(12);

        // BL=8, cl=0: beats 0x10..0x17 over T+1..T+4, valid at T+5
        drive(1'b1, 6'd0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) drive(1'b0, 6'd0, 8'(8'h10 + 2*k), 8'(8'h11 + 2*k));
        drive(1'b0, 6'd0, 8'h00, 8'h00);
        chk("t2_valid", 64'(g_dut[1].u_if.rd_valid), 64'd1);
        chk("t2_data",  64'(g_dut[1].u_if.rd_data),  64'h1716151413121110);
        idle_cycles(12);

        // rd_cmd held: busy cycles overflow, rd_valid cycle accepts again
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, 6'd2, 8'(k), 8'(~k));
            if (g_dut[0].u_if.rd_valid) chk("t3_rdy_in_valid", 64'(g_dut[0].u_if.rd_rdy), 64'd1);
        end
        idle_cycles(12);

        // reset at T+2 of a cl=5 burst
        drive(1'b1, 6'd5, 8'h00, 8'h00);
        idle_cycles(1);
        @(negedge clk) begin rst = 1'b0; rd_cmd = 1'b0; end
        @(negedge clk) rst = 1'b1;
        chk("t4_rdy",  64'(g_dut[0].u_if.rd_rdy),  64'd1);
        chk("t4_data", 64'(g_dut[0].u_if.rd_data), 64'd0);
        idle_cycles(10);
        chk("t4_no_valid", 64'(g_dut[0].u_if.rd_valid), 64'd0);
        drive(1'b1, 6'd1, 8'h00, 8'h00);
        drive(1'b0, 6'd0, 8'h00, 8'h00);
        drive(1'b0, 6'd0, 8'h5A, 8'hC3);
        drive(1'b0, 6'd0, 8'h00, 8'h00);
        chk("t4_fresh", 64'(g_dut[0].u_if.rd_data), 64'hC35A);
        idle_cycles(12);

`ifdef RD_DBI_EN
        drive(1'b1, 6'd0, 8'h00, 8'h00);
        @(negedge clk) begin
            rd_cmd = 1'b0; dq_rise = 8'h0F; dq_fall = 8'h0F;
            dbi_n_rise = 1'b0; dbi_n_fall = 1'b1;
        end
        drive(1'b0, 6'd0, 8'h00, 8'h00);
        chk("t5_dbi", 64'(g_dut[0].u_if.rd_data), 64'h0FF0);
        idle_cycles(12);
`endif

        // cl=63: BL=2 instance valid exactly at T+65
        drive(1'b1, 6'd63, 8'h00, 8'h00);
        for (int k = 1; k < 65; k++) begin
            drive(1'b0, 6'd0, 8'(k), 8'(k + 7));
            if (k < 64) begin
                if (g_dut[0].u_if.rd_valid) chk("t6_early", 64'(g_dut[0].u_if.rd_valid), 64'd0);
            end
        end
        drive(1'b0, 6'd0, 8'h00, 8'h00);
        chk("t6_valid", 64'(g_dut[0].u_if.rd_valid), 64'd1);
        chk("t6_data",  64'(g_dut[0].u_if.rd_data),  64'h4740);
        idle_cycles(72);

        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 99) >= 2);
            rd_cmd     = ($urandom_range(0, 99) < 40);
            cl         = ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            dq_rise    = 8'($urandom);
            dq_fall    = 8'($urandom);
`ifdef RD_DBI_EN
            dbi_n_rise = 1'($urandom);
            dbi_n_fall = 1'($urandom);
`else
            dbi_n_rise = 1'b1;
            dbi_n_fall = 1'b1;
`endif
        end
        @(negedge clk) begin rst = 1'b1; rd_cmd = 1'b0; end
        idle_cycles(80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
